// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle MIPS sequencer.
// The master side is the sequencer; the slave side is the datapath and memory.
interface mips_multicycle_control_if #(
  parameter int COUNT_W = 32
);
  logic               pause;
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic [1:0]         PCSource;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               link;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         ALUOp;
  logic [3:0]         state;
  logic               instr_done;
  logic [COUNT_W-1:0] instr_count;
  logic               trap;
  logic               timeout;

  modport master (
    input  pause, opcode, mem_ready,
    output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, link, ALUSrcA, ALUSrcB, ALUOp,
           state, instr_done, instr_count, trap, timeout
  );

  modport slave (
    output pause, opcode, mem_ready,
    input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, link, ALUSrcA, ALUSrcB, ALUOp,
           state, instr_done, instr_count, trap, timeout
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS sequencer with memory wait states, pause, trap on
// illegal opcode or memory timeout, and a retired-instruction counter.
//
// state     | meaning
// ----------+---------------------------------------------
// FETCH     | read instruction at PC, PC <= PC+4
// DECODE    | dispatch on opcode, precompute branch target
// MEM_ADDR  | rs + sign-extended offset
// MEM_READ  | load from ALUOut, wait for mem_ready
// MEM_WB    | MDR -> rt
// MEM_WRITE | store to ALUOut, wait for mem_ready
// R_EXEC    | rs op rt
// R_WB      | ALUOut -> rd
// BRANCH    | compare rs/rt, conditional PC load
// JUMP      | PC <= jump target
// JAL       | PC <= jump target, PC+4 -> $31
// ADDI_EXEC | rs + immediate
// ADDI_WB   | ALUOut -> rt
// TRAP      | halted until reset
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int COUNT_W     = 32
) (
  input logic                        CLOCK_50,
  input logic                        reset,
  mips_multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JAL       = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  state_t             state_q, next_state;
  logic [WAIT_W-1:0]  wait_q, wait_next;
  logic [COUNT_W-1:0] count_q;
  logic               trap_q, timeout_q;
  logic               waiting, go_timeout, retire, strobe_en;

  logic pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, link_s;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      count_q   <= '0;
      trap_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= next_state;
      wait_q  <= wait_next;
      if (retire)               count_q   <= count_q + COUNT_W'(1);
      if (next_state == S_TRAP) trap_q    <= 1'b1;
      if (go_timeout)           timeout_q <= 1'b1;
    end
  end

  // Pause freezes everything: the state, the wait counter and any mem_ready seen.
  always_comb begin
    next_state = state_q;
    wait_next  = wait_q;
    waiting    = 1'b0;
    go_timeout = 1'b0;
    if (!bus.pause) begin
      case (state_q)
        S_FETCH:     if (bus.mem_ready) next_state = S_DECODE; else waiting = 1'b1;
        S_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: next_state = S_MEM_ADDR;
            OP_R:         next_state = S_R_EXEC;
            OP_BEQ:       next_state = S_BRANCH;
            OP_J:         next_state = S_JUMP;
            OP_JAL:       next_state = S_JAL;
            OP_ADDI:      next_state = S_ADDI_EXEC;
            default:      next_state = S_TRAP;
          endcase
        end
        S_MEM_ADDR:  next_state = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (bus.mem_ready) next_state = S_MEM_WB; else waiting = 1'b1;
        S_MEM_WB:    next_state = S_FETCH;
        S_MEM_WRITE: if (bus.mem_ready) next_state = S_FETCH; else waiting = 1'b1;
        S_R_EXEC:    next_state = S_R_WB;
        S_R_WB:      next_state = S_FETCH;
        S_BRANCH:    next_state = S_FETCH;
        S_JUMP:      next_state = S_FETCH;
        S_JAL:       next_state = S_FETCH;
        S_ADDI_EXEC: next_state = S_ADDI_WB;
        S_ADDI_WB:   next_state = S_FETCH;
        S_TRAP:      next_state = S_TRAP;
        default:     next_state = S_FETCH;
      endcase
      if (waiting) begin
        // The cycle that completes MEM_TIMEOUT waits traps; mem_ready already took priority above.
        if (MEM_TIMEOUT != 0 && wait_q == WAIT_LAST) begin
          next_state = S_TRAP;
          go_timeout = 1'b1;
        end
        wait_next = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
      end else begin
        wait_next = '0;
      end
    end
  end

  assign retire    = (state_q != S_FETCH) && (next_state == S_FETCH);
  assign strobe_en = !bus.pause && !reset;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    link_s        = 1'b0;
    bus.PCSource  = 2'b00;
    bus.IorD      = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.RegDst    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ALUOp     = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        ir_write    = bus.mem_ready;
        pc_write    = bus.mem_ready;
        bus.ALUSrcB = 2'b01;
      end
      S_DECODE:    bus.ALUSrcB = 2'b11;
      S_MEM_ADDR:  begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; end
      S_MEM_READ:  begin mem_read = 1'b1; bus.IorD = 1'b1; end
      S_MEM_WB:    begin reg_write = 1'b1; bus.MemtoReg = 1'b1; end
      S_MEM_WRITE: begin mem_write = 1'b1; bus.IorD = 1'b1; end
      S_R_EXEC:    begin bus.ALUSrcA = 1'b1; bus.ALUOp = 3'b010; end
      S_R_WB:      begin bus.RegDst = 1'b1; reg_write = 1'b1; end
      S_BRANCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUOp     = 3'b001;
        pc_write_cond = 1'b1;
        bus.PCSource  = 2'b01;
      end
      S_JUMP:      begin pc_write = 1'b1; bus.PCSource = 2'b10; end
      S_JAL: begin
        pc_write     = 1'b1;
        bus.PCSource = 2'b10;
        reg_write    = 1'b1;
        link_s       = 1'b1;
      end
      S_ADDI_EXEC: begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; end
      S_ADDI_WB:   reg_write = 1'b1;
      default:     ;
    endcase
  end

  assign bus.PCWrite     = pc_write      & strobe_en;
  assign bus.PCWriteCond = pc_write_cond & strobe_en;
  assign bus.MemRead     = mem_read      & strobe_en;
  assign bus.MemWrite    = mem_write     & strobe_en;
  assign bus.IRWrite     = ir_write      & strobe_en;
  assign bus.RegWrite    = reg_write     & strobe_en;
  assign bus.link        = link_s        & strobe_en;
  assign bus.instr_done  = retire        & strobe_en;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;
  assign bus.trap        = trap_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed vector bench for mips_multicycle_control: a per-cycle table for the
// instruction flows plus hand sequences for trap hold, reset abort and timeout.
module tb_mips_multicycle_control;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  logic reset_to = 1'b1;

  always #10 CLOCK_50 = ~CLOCK_50;

  mips_multicycle_control_if #(.COUNT_W(32)) bus ();
  mips_multicycle_control_if #(.COUNT_W(32)) bus_to ();

  mips_multicycle_control #(.MEM_TIMEOUT(255), .COUNT_W(32)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  mips_multicycle_control #(.MEM_TIMEOUT(4), .COUNT_W(32)) dut_to (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset_to),
    .bus      (bus_to)
  );

  typedef struct {
    logic        rst;
    logic        pause;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] ctrl;
    logic [31:0] cnt;
    logic        trap;
    logic        tmo;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000, BAD = 6'b111111;

  // Packing order: PCWrite PCWriteCond PCSource IorD MemRead MemWrite IRWrite
  //                MemtoReg RegDst RegWrite link ALUSrcA ALUSrcB ALUOp instr_done
  function automatic logic [18:0] c(input logic pcw, input logic pcwc, input logic [1:0] pcs,
                                    input logic iord, input logic mr, input logic mw,
                                    input logic irw, input logic m2r, input logic rdst,
                                    input logic rw, input logic lnk, input logic srca,
                                    input logic [1:0] srcb, input logic [2:0] aluop,
                                    input logic done);
    return {pcw, pcwc, pcs, iord, mr, mw, irw, m2r, rdst, rw, lnk, srca, srcb, aluop, done};
  endfunction

  function automatic logic [18:0] act_ctrl();
    return {bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.link, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.instr_done};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic p, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [18:0] cx, input logic [31:0] cn,
                     input logic tp, input logic tm);
    vec_t v;
    v.rst = r; v.pause = p; v.op = op; v.rdy = rdy; v.st = st;
    v.ctrl = cx; v.cnt = cn; v.trap = tp; v.tmo = tm;
    vecs.push_back(v);
  endtask

  logic [18:0] C_FETCH_RDY, C_FETCH_WAIT, C_FETCH_QUIET, C_DECODE, C_MEM_ADDR, C_MEM_READ;
  logic [18:0] C_MEM_WB, C_MW_WAIT, C_MW_RDY, C_R_EXEC, C_R_WB, C_BRANCH, C_JUMP, C_JAL;
  logic [18:0] C_ADDI_EXEC, C_ADDI_WB, C_NONE;

  initial begin
    bus.pause = 1'b0; bus.opcode = R; bus.mem_ready = 1'b1;
    bus_to.pause = 1'b0; bus_to.opcode = R; bus_to.mem_ready = 1'b0;

    //                  pcw pcwc pcs  iord mr mw irw m2r rdst rw lnk srca srcb  aluop   done
    C_FETCH_RDY   = c(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 3'b000, 0);
    C_FETCH_WAIT  = c(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 0);
    C_FETCH_QUIET = c(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 0);
    C_DECODE      = c(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 0);
    C_MEM_ADDR    = c(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0);
    C_MEM_READ    = c(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    C_MEM_WB      = c(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 3'b000, 1);
    C_MW_WAIT     = c(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    C_MW_RDY      = c(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1);
    C_R_EXEC      = c(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0);
    C_R_WB        = c(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 1);
    C_BRANCH      = c(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 1);
    C_JUMP        = c(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1);
    C_JAL         = c(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 1);
    C_ADDI_EXEC   = c(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0);
    C_ADDI_WB     = c(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'b000, 1);
    C_NONE        = '0;

    //   rst p  op    rdy st    ctrl           cnt trap tmo
    add(1, 0, R,    1,  0, C_FETCH_QUIET, 0, 0, 0);
    // R-type, zero wait
    add(0, 0, R,    1,  0, C_FETCH_RDY,   0, 0, 0);
    add(0, 0, R,    1,  1, C_DECODE,      0, 0, 0);
    add(0, 0, R,    1,  6, C_R_EXEC,      0, 0, 0);
    add(0, 0, R,    1,  7, C_R_WB,        0, 0, 0);
    // lw with three wait cycles in MEM_READ: 8 cycles total
    add(0, 0, LW,   1,  0, C_FETCH_RDY,   1, 0, 0);
    add(0, 0, LW,   1,  1, C_DECODE,      1, 0, 0);
    add(0, 0, LW,   1,  2, C_MEM_ADDR,    1, 0, 0);
    add(0, 0, LW,   0,  3, C_MEM_READ,    1, 0, 0);
    add(0, 0, LW,   0,  3, C_MEM_READ,    1, 0, 0);
    add(0, 0, LW,   0,  3, C_MEM_READ,    1, 0, 0);
    add(0, 0, LW,   1,  3, C_MEM_READ,    1, 0, 0);
    add(0, 0, LW,   1,  4, C_MEM_WB,      1, 0, 0);
    // beq then jal
    add(0, 0, BEQ,  1,  0, C_FETCH_RDY,   2, 0, 0);
    add(0, 0, BEQ,  1,  1, C_DECODE,      2, 0, 0);
    add(0, 0, BEQ,  1,  8, C_BRANCH,      2, 0, 0);
    add(0, 0, JAL,  1,  0, C_FETCH_RDY,   3, 0, 0);
    add(0, 0, JAL,  1,  1, C_DECODE,      3, 0, 0);
    add(0, 0, JAL,  1, 10, C_JAL,         3, 0, 0);
    // sw with one wait cycle
    add(0, 0, SW,   1,  0, C_FETCH_RDY,   4, 0, 0);
    add(0, 0, SW,   1,  1, C_DECODE,      4, 0, 0);
    add(0, 0, SW,   1,  2, C_MEM_ADDR,    4, 0, 0);
    add(0, 0, SW,   0,  5, C_MW_WAIT,     4, 0, 0);
    add(0, 0, SW,   1,  5, C_MW_RDY,      4, 0, 0);
    // addi, j
    add(0, 0, ADDI, 1,  0, C_FETCH_RDY,   5, 0, 0);
    add(0, 0, ADDI, 1,  1, C_DECODE,      5, 0, 0);
    add(0, 0, ADDI, 1, 11, C_ADDI_EXEC,   5, 0, 0);
    add(0, 0, ADDI, 1, 12, C_ADDI_WB,     5, 0, 0);
    add(0, 0, J,    1,  0, C_FETCH_RDY,   6, 0, 0);
    add(0, 0, J,    1,  1, C_DECODE,      6, 0, 0);
    add(0, 0, J,    1,  9, C_JUMP,        6, 0, 0);
    // R-type paused five cycles in R_EXEC
    add(0, 0, R,    1,  0, C_FETCH_RDY,   7, 0, 0);
    add(0, 0, R,    1,  1, C_DECODE,      7, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 1, R, 1, 6, C_R_EXEC, 7, 0, 0);
    add(0, 0, R,    1,  6, C_R_EXEC,      7, 0, 0);
    add(0, 0, R,    1,  7, C_R_WB,        7, 0, 0);
    // pause in FETCH swallows mem_ready; memory must reassert it
    add(0, 1, R,    1,  0, C_FETCH_QUIET, 8, 0, 0);
    add(0, 0, R,    0,  0, C_FETCH_WAIT,  8, 0, 0);
    add(0, 0, BAD,  1,  0, C_FETCH_RDY,   8, 0, 0);
    // illegal opcode
    add(0, 0, BAD,  1,  1, C_DECODE,      8, 0, 0);
    add(0, 0, BAD,  1, 13, C_NONE,        8, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLOCK_50);
      reset         = vecs[i].rst;
      bus.pause     = vecs[i].pause;
      bus.opcode    = vecs[i].op;
      bus.mem_ready = vecs[i].rdy;
      #2;
      chk("state", i, 32'(bus.state), 32'(vecs[i].st));
      chk("ctrl", i, 32'(act_ctrl()), 32'(vecs[i].ctrl));
      chk("instr_count", i, bus.instr_count, vecs[i].cnt);
      chk("trap_timeout", i, 32'({bus.trap, bus.timeout}), 32'({vecs[i].trap, vecs[i].tmo}));
    end

    // TRAP is sticky for 100 cycles, then reset clears it with strobes held low
    repeat (100) @(posedge CLOCK_50);
    @(negedge CLOCK_50); #2;
    chk("trap_hold_state", 0, 32'(bus.state), 32'd13);
    chk("trap_hold_flags", 0, 32'({bus.trap, bus.timeout}), 32'b10);
    chk("trap_hold_ctrl", 0, 32'(act_ctrl()), 32'(C_NONE));
    reset = 1'b1; #1;
    chk("trap_reset_state", 0, 32'(bus.state), 32'd0);
    chk("trap_reset_flags", 0, 32'({bus.trap, bus.timeout}), 32'b00);
    chk("trap_reset_ctrl", 0, 32'(act_ctrl()), 32'(C_FETCH_QUIET));
    chk("trap_reset_count", 0, bus.instr_count, 32'd0);

    // reset in the middle of a stalled store
    @(negedge CLOCK_50);
    reset = 1'b0; bus.opcode = SW; bus.mem_ready = 1'b1; bus.pause = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    bus.mem_ready = 1'b0; #2;
    chk("sw_stall_state", 0, 32'(bus.state), 32'd5);
    chk("sw_stall_memwrite", 0, 32'(bus.MemWrite), 32'd1);
    reset = 1'b1; #1;
    chk("sw_abort_memwrite", 0, 32'(bus.MemWrite), 32'd0);
    chk("sw_abort_state", 0, 32'(bus.state), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;

    // MEM_TIMEOUT=4: four waiting FETCH cycles, then TRAP with timeout
    reset_to = 1'b0; bus_to.mem_ready = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50); #2;
    chk("to_before_state", 0, 32'(bus_to.state), 32'd0);
    chk("to_before_flags", 0, 32'({bus_to.trap, bus_to.timeout}), 32'b00);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50); #2;
    chk("to_state", 0, 32'(bus_to.state), 32'd13);
    chk("to_flags", 0, 32'({bus_to.trap, bus_to.timeout}), 32'b11);

    // mem_ready on the fourth waiting cycle wins over the timeout
    reset_to = 1'b1;
    @(negedge CLOCK_50);
    reset_to = 1'b0; bus_to.mem_ready = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    bus_to.mem_ready = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50); #2;
    chk("to_ready_wins_state", 0, 32'(bus_to.state), 32'd1);
    chk("to_ready_wins_flags", 0, 32'({bus_to.trap, bus_to.timeout}), 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
